// File: rtl/prau_dispatch.sv
// ============================================================================
// Module : prau_dispatch
// Brief  : Request FIFO and single-outstanding issue/collect/writeback sequencer for the PRAU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package prau_pkg;
   typedef enum logic [3:0] {
      NONE   = 4'd0,
      PADD   = 4'd1,
      PSUB   = 4'd2,
      PMUL   = 4'd3,
      PDIV   = 4'd4,
      PSQRT  = 4'd5,
      PMIN   = 4'd6,
      PMAX   = 4'd7,
      PSGNJ  = 4'd8,
      PCVT   = 4'd9,
      QCLR   = 4'd10,
      QMADD  = 4'd11,
      QMSUB  = 4'd12,
      QROUND = 4'd13
   } prau_op_e;
endpackage

module prau_dispatch
   import prau_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int DEPTH   = 4,
   parameter int RD_W    = 5,
   parameter int SEQ_W   = 3,
   parameter int TIMEOUT = 64,
   localparam int TAG_W  = SEQ_W + RD_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  prau_op_e         req_op_i,
   input  logic [XLEN-1:0]  req_a_i,
   input  logic [XLEN-1:0]  req_b_i,
   input  logic [RD_W-1:0]  req_rd_i,
   output logic             prau_valid_o,
   input  logic             prau_ready_i,
   output logic [XLEN-1:0]  prau_a_o,
   output logic [XLEN-1:0]  prau_b_o,
   output prau_op_e         prau_op_o,
   output logic [TAG_W-1:0] prau_tag_o,
   input  logic             prau_rvalid_i,
   output logic             prau_rready_o,
   input  logic [TAG_W-1:0] prau_rtag_i,
   input  logic [XLEN-1:0]  prau_result_i,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic [RD_W-1:0]  wb_rd_o,
   output logic [XLEN-1:0]  wb_result_o,
   output logic             wb_err_o,
   output logic             busy_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int WD_W  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } state_e;

   state_e            r_state, w_state_nxt;
   prau_op_e          r_mem_op [DEPTH];
   logic [XLEN-1:0]   r_mem_a  [DEPTH];
   logic [XLEN-1:0]   r_mem_b  [DEPTH];
   logic [RD_W-1:0]   r_mem_rd [DEPTH];
   logic [PTR_W:0]    r_wptr, r_rptr;
   logic [SEQ_W-1:0]  r_seq;
   logic              r_drain;
   logic [WD_W-1:0]   r_wdog;
   prau_op_e          r_op;
   logic [XLEN-1:0]   r_a, r_b;
   logic [TAG_W-1:0]  r_tag;
   logic [RD_W-1:0]   r_wb_rd;
   logic [XLEN-1:0]   r_wb_result;
   logic              r_wb_err;

   logic              w_empty, w_full, w_push, w_avail, w_can_issue;
   logic              w_load, w_capture, w_timeout, w_rhs;
   prau_op_e          w_head_op;
   logic [XLEN-1:0]   w_head_a, w_head_b;
   logic [RD_W-1:0]   w_head_rd;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                    (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
   assign w_push  = req_valid_i & ~w_full;

   // An empty FIFO forwards the incoming request so it can issue on the cycle after the push.
   assign w_avail     = ~w_empty | w_push;
   assign w_can_issue = w_avail & ~r_drain;
   assign w_head_op   = w_empty ? req_op_i : r_mem_op[r_rptr[PTR_W-1:0]];
   assign w_head_a    = w_empty ? req_a_i  : r_mem_a[r_rptr[PTR_W-1:0]];
   assign w_head_b    = w_empty ? req_b_i  : r_mem_b[r_rptr[PTR_W-1:0]];
   assign w_head_rd   = w_empty ? req_rd_i : r_mem_rd[r_rptr[PTR_W-1:0]];

   assign prau_rready_o = (r_state == ST_WAIT) | r_drain;
   assign w_rhs         = prau_rvalid_i & prau_rready_o;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_can_issue) begin
               w_load      = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (prau_ready_i) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_rhs && (prau_rtag_i == r_tag)) begin
               if ((r_op == QMADD) || (r_op == QMSUB)) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_WB;
               end
            end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_WB;
            end
         end
         ST_WB: begin
            if (wb_ready_i) begin
               if (w_can_issue) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_op[r_wptr[PTR_W-1:0]] <= req_op_i;
         r_mem_a[r_wptr[PTR_W-1:0]]  <= req_a_i;
         r_mem_b[r_wptr[PTR_W-1:0]]  <= req_b_i;
         r_mem_rd[r_wptr[PTR_W-1:0]] <= req_rd_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_seq       <= '0;
         r_drain     <= 1'b0;
         r_wdog      <= '0;
         r_op        <= NONE;
         r_a         <= '0;
         r_b         <= '0;
         r_tag       <= '0;
         r_wb_rd     <= '0;
         r_wb_result <= '0;
         r_wb_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) r_wptr <= r_wptr + (PTR_W + 1)'(1);
         if (w_load) begin
            r_rptr <= r_rptr + (PTR_W + 1)'(1);
            r_op   <= w_head_op;
            r_a    <= w_head_a;
            r_b    <= w_head_b;
            r_tag  <= {r_seq, w_head_rd};
            r_seq  <= r_seq + SEQ_W'(1);
         end
         if ((r_state == ST_ISSUE) && prau_ready_i) r_wdog <= '0;
         else if (r_state == ST_WAIT)               r_wdog <= r_wdog + WD_W'(1);
         if (w_capture) begin
            r_wb_rd     <= r_tag[RD_W-1:0];
            r_wb_result <= prau_result_i;
            r_wb_err    <= 1'b0;
         end
         // Drain only spans states other than WAIT, so any accepted result is the stale one.
         if (r_drain && prau_rvalid_i) r_drain <= 1'b0;
         if (w_timeout) begin
            r_wb_rd     <= r_tag[RD_W-1:0];
            r_wb_result <= '0;
            r_wb_err    <= 1'b1;
            r_drain     <= 1'b1;
         end
      end
   end

   assign req_ready_o  = ~w_full;
   assign prau_valid_o = (r_state == ST_ISSUE);
   assign prau_a_o     = r_a;
   assign prau_b_o     = r_b;
   assign prau_op_o    = r_op;
   assign prau_tag_o   = r_tag;
   assign wb_valid_o   = (r_state == ST_WB);
   assign wb_rd_o      = r_wb_rd;
   assign wb_result_o  = r_wb_result;
   assign wb_err_o     = r_wb_err;
   assign busy_o       = ~w_empty | (r_state != ST_IDLE);

endmodule

`default_nettype wire
